// File: rtl/conv_win_pkg.sv
// conv_win_pkg: shared pixel/window types, FSM states and counter-width helper.
// Provides a default `WID_LINE pixel width when the build does not define one.
`ifndef WID_LINE
`define WID_LINE 16
`endif
package conv_win_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    typedef logic signed [`WID_LINE-1:0] pix_t;
    typedef logic signed [`WID_LINE-1:0] win_t [9];
    function automatic int cnt_w(input int max_w);
        return $clog2(max_w + 1);
    endfunction
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: frame control, pixel stream and window outputs of the window generator.
// Signals: start/img_w/img_h (frame setup), in_valid/in_pixel (pixel stream),
// win_valid/win/win_row/win_col (window), busy/frame_done/cfg_err (status).
// master = pixel source / window consumer, slave = conv_window_gen.
interface conv_window_gen_if #(
    parameter int CNT_W = 9
) ();
    import conv_win_pkg::*;
    logic             start;
    logic [CNT_W-1:0] img_w;
    logic [CNT_W-1:0] img_h;
    logic             in_valid;
    pix_t             in_pixel;
    logic             win_valid;
    win_t             win;
    logic [CNT_W-1:0] win_row;
    logic [CNT_W-1:0] win_col;
    logic             busy;
    logic             frame_done;
    logic             cfg_err;
    modport master (
        output start, img_w, img_h, in_valid, in_pixel,
        input  win_valid, win, win_row, win_col, busy, frame_done, cfg_err
    );
    modport slave (
        input  start, img_w, img_h, in_valid, in_pixel,
        output win_valid, win, win_row, win_col, busy, frame_done, cfg_err
    );
endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of pixels, 1R1W, combinational read, read-before-write.
// Ports: clk, i_we (write enable), i_addr (shared read/write column), i_wdata, o_rdata.
module conv_line_buffer import conv_win_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  pix_t          i_wdata,
    output pix_t          o_rdata
);
    pix_t r_mem [DEPTH];
    assign o_rdata = r_mem[i_addr];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into registered 3x3 windows.
// Ports: clk, rst (asynchronous, active-high), bus (conv_window_gen_if.slave).
// Build option CONV_WIN_STRIDE2_EN: emit only windows at even row/column offsets
// and report their indices halved.
module conv_window_gen import conv_win_pkg::*; #(
    parameter int MAX_W = 256,
    parameter int CNT_W = cnt_w(MAX_W)
) (
    input logic              clk,
    input logic              rst,
    conv_window_gen_if.slave bus
);
    localparam int AW = $clog2(MAX_W);
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_w, r_h, r_row, r_col, w_win_row, w_win_col;
    win_t             r_win, w_win_nxt;
    pix_t             w_lb1_rd, w_lb2_rd;
    logic             w_acc, w_col_end, w_last, w_legal, w_gate;

    assign w_acc     = (r_state == RUN) && bus.in_valid;
    assign w_col_end = r_col == r_w - CNT_W'(1);
    assign w_last    = w_col_end && (r_row == r_h - CNT_W'(1));
    assign w_legal   = bus.img_w >= CNT_W'(3) && bus.img_w <= CNT_W'(MAX_W) && bus.img_h >= CNT_W'(3);
`ifdef CONV_WIN_STRIDE2_EN
    assign w_gate    = r_row >= CNT_W'(2) && r_col >= CNT_W'(2) && !r_row[0] && !r_col[0];
    assign w_win_row = (r_row - CNT_W'(2)) >> 1;
    assign w_win_col = (r_col - CNT_W'(2)) >> 1;
`else
    assign w_gate    = r_row >= CNT_W'(2) && r_col >= CNT_W'(2);
    assign w_win_row = r_row - CNT_W'(2);
    assign w_win_col = r_col - CNT_W'(2);
`endif
    assign bus.busy = r_state == RUN;

    // lb1 holds row r-1, lb2 holds row r-2; each accept pushes the column one row older.
    conv_line_buffer #(.DEPTH(MAX_W), .AW(AW)) u_lb1 (
        .clk(clk), .i_we(w_acc), .i_addr(r_col[AW-1:0]), .i_wdata(bus.in_pixel), .o_rdata(w_lb1_rd)
    );
    conv_line_buffer #(.DEPTH(MAX_W), .AW(AW)) u_lb2 (
        .clk(clk), .i_we(w_acc), .i_addr(r_col[AW-1:0]), .i_wdata(w_lb1_rd), .o_rdata(w_lb2_rd)
    );

    // Shift every window row left; the new right-hand column is oldest row on top.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_win_nxt[3*k]   = r_win[3*k+1];
            w_win_nxt[3*k+1] = r_win[3*k+2];
        end
        w_win_nxt[2] = w_lb2_rd;
        w_win_nxt[5] = w_lb1_rd;
        w_win_nxt[8] = bus.in_pixel;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == IDLE) ? ((bus.start && w_legal) ? RUN : IDLE)
                                        : ((w_acc && w_last) ? IDLE : RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w            <= '0;
            r_h            <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_win          <= '{default: '0};
            bus.win        <= '{default: '0};
            bus.win_row    <= '0;
            bus.win_col    <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.cfg_err    <= 1'b0;
        end else begin
            bus.win_valid  <= w_acc && w_gate;
            bus.frame_done <= w_acc && w_last;
            bus.cfg_err    <= (r_state == IDLE) && bus.start && !w_legal;
            if (r_state == IDLE && bus.start && w_legal) begin
                r_w   <= bus.img_w;
                r_h   <= bus.img_h;
                r_row <= '0;
                r_col <= '0;
            end
            if (w_acc) begin
                r_win <= w_win_nxt;
                r_col <= w_col_end ? '0 : r_col + CNT_W'(1);
                if (w_col_end) r_row <= r_row + CNT_W'(1);
                if (w_gate) begin
                    bus.win     <= w_win_nxt;
                    bus.win_row <= w_win_row;
                    bus.win_col <= w_win_col;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized scoreboard bench for conv_window_gen.
// Frames are stored as whole images; every expected window is cut directly out of
// the stored image and queued with the cycle it must appear on.
module tb_conv_window_gen;
    import conv_win_pkg::*;
    localparam int MAX_W = 256;
    localparam int CW    = cnt_w(MAX_W);
`ifdef CONV_WIN_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
`else
    localparam bit STRIDE2 = 1'b0;
`endif

    typedef struct {
        pix_t w [9];
        int   row;
        int   col;
        int   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_win = 0;
    int   n_done = 0;
    int   n_frames_exp = 0;
    exp_t exp_q[$];
    int   done_q[$];
    exp_t m_e;
    pix_t img [64][MAX_W];
    pix_t last_win [9];

    conv_window_gen_if #(.CNT_W(CW)) bus ();
    conv_window_gen #(.MAX_W(MAX_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nwin(input int w, input int h);
        return STRIDE2 ? ((w - 1) / 2) * ((h - 1) / 2) : (w - 2) * (h - 2);
    endfunction

    function automatic bit win_expected(input int r, input int c);
        return r >= 2 && c >= 2 && (!STRIDE2 || ((r - 2) % 2 == 0 && (c - 2) % 2 == 0));
    endfunction

    // Monitor: every presented window and frame_done is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.win_valid) begin
                n_win++;
                for (int k = 0; k < 9; k++) last_win[k] = bus.win[k];
                if (exp_q.size() == 0) check("unexpected_window", 1, 0);
                else begin
                    m_e = exp_q.pop_front();
                    check("win_cycle", cyc, m_e.cyc);
                    for (int k = 0; k < 9; k++) check($sformatf("win_%0d", k + 1), bus.win[k], m_e.w[k]);
                    check("win_row", bus.win_row, m_e.row);
                    check("win_col", bus.win_col, m_e.col);
                end
            end
            if (bus.frame_done) begin
                n_done++;
                if (done_q.size() == 0) check("unexpected_frame_done", 1, 0);
                else check("frame_done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h);
        bus.start = 1'b1;
        bus.img_w = CW'(w);
        bus.img_h = CW'(h);
        tick();
        bus.start = 1'b0;
    endtask

    // Sends npix pixels of a w x h frame; poke raises a stray start mid-frame.
    task automatic send_frame(input int w, input int h, input int npix, input bit rnd,
                              input int base, input int gap, input bit poke);
        int   r, c;
        pix_t p;
        exp_t e;
        start_frame(w, h);
        for (int k = 0; k < npix; k++) begin
            while ($urandom_range(99) < gap) begin
                bus.in_valid = 1'b0;
                bus.in_pixel = pix_t'($urandom);
                tick();
            end
            r = k / w;
            c = k % w;
            p = rnd ? pix_t'($urandom) : pix_t'(base + k);
            img[r][c] = p;
            bus.in_valid = 1'b1;
            bus.in_pixel = p;
            bus.start = poke && k == 4;
            bus.img_w = bus.start ? CW'(3) : bus.img_w;
            if (win_expected(r, c)) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) e.w[3*i+j] = img[r-2+i][c-2+j];
                e.row = STRIDE2 ? (r - 2) / 2 : r - 2;
                e.col = STRIDE2 ? (c - 2) / 2 : c - 2;
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            if (k == w * h - 1) begin
                done_q.push_back(cyc + 1);
                n_frames_exp++;
            end
            tick();
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int n0;
        int bad [4][2];
        bad = '{'{2, 4}, '{257, 4}, '{4, 2}, '{0, 0}};
        bus.start = 1'b0;
        bus.img_w = '0;
        bus.img_h = '0;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_win_row", bus.win_row, 0);
        check("rst_win_1", bus.win[0], 0);
        check("rst_win_9", bus.win[8], 0);

        // 4x4 contiguous, then the same frame back-to-back with 50% gaps
        n0 = n_win;
        send_frame(4, 4, 16, 1'b0, 0, 0, 1'b0);
        send_frame(4, 4, 16, 1'b0, 0, 50, 1'b0);
        repeat (3) tick();
        check("t_4x4_window_count", n_win - n0, 2 * nwin(4, 4));

        // 5x3 signed frame
        n0 = n_win;
        send_frame(5, 3, 15, 1'b0, -7, 0, 1'b0);
        repeat (3) tick();
        check("t_5x3_window_count", n_win - n0, nwin(5, 3));
        check("t_5x3_last_win_1", last_win[0], -5);
        check("t_5x3_last_win_5", last_win[4], 1);
        check("t_5x3_last_win_9", last_win[8], 7);

        // illegal dimensions
        for (int b = 0; b < 4; b++) begin
            start_frame(bad[b][0], bad[b][1]);
            check("cfg_err_pulse", bus.cfg_err, 1);
            check("cfg_err_busy", bus.busy, 0);
            bus.in_valid = 1'b1;
            bus.in_pixel = pix_t'($urandom);
            tick();
            check("cfg_err_clear", bus.cfg_err, 0);
            repeat (4) tick();
            bus.in_valid = 1'b0;
            check("cfg_err_busy_after", bus.busy, 0);
        end

        // abort a 6x6 frame after 9 pixels, then a fresh 4x4 frame
        send_frame(6, 6, 9, 1'b1, 0, 0, 1'b0);
        check("abort_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_win_valid", bus.win_valid, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        n0 = n_win;
        send_frame(4, 4, 16, 1'b1, 0, 20, 1'b0);
        repeat (3) tick();
        check("abort_next_window_count", n_win - n0, nwin(4, 4));

        // 6x6 0..35 (stride-2 reference case)
        n0 = n_win;
        send_frame(6, 6, 36, 1'b0, 0, 0, 1'b0);
        repeat (3) tick();
        check("t_6x6_window_count", n_win - n0, nwin(6, 6));

        // random frames, with a stray start inside one of them
        for (int f = 0; f < 6; f++) begin
            int w, h;
            w = $urandom_range(12, 3);
            h = $urandom_range(8, 3);
            n0 = n_win;
            send_frame(w, h, w * h, 1'b1, 0, 30, f == 2);
            repeat (3) tick();
            check($sformatf("rand_%0dx%0d_window_count", w, h), n_win - n0, nwin(w, h));
        end

        // maximum width
        n0 = n_win;
        send_frame(MAX_W, 3, MAX_W * 3, 1'b0, -300, 0, 1'b0);
        repeat (3) tick();
        check("max_w_window_count", n_win - n0, nwin(MAX_W, 3));
        check("max_w_last_win_9", last_win[8], -300 + 3 * MAX_W - 1);

        repeat (5) tick();
        check("exp_queue_drained", exp_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        check("frame_done_total", n_done, n_frames_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
